pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_pkg.sv | 18 +
 rtl/pipe_ctrl_perf.sv | 20 ++
 rtl/pipe_ctrl.sv | 146 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline-control definitions: controller state encoding and opcode constants.
package pipe_pkg;

  localparam int unsigned STATE_W     = 2;
  localparam int unsigned OPC_W       = 6;
  localparam int unsigned STALL_CNT_W = 32;

  // NOOP opcode that the datapath muxes in wherever a bubble is requested.
  localparam logic [OPC_W-1:0] NOOP_OPC = OPC_W'(0);

  typedef enum logic [STATE_W-1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

endpackage

// File: rtl/pipe_ctrl_perf.sv
// Saturating counter of RUN cycles in which decode is held.
module pipe_ctrl_perf
  import pipe_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  output logic [STALL_CNT_W-1:0] count
);

  // Count enabled cycles and stick at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + STALL_CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Dual-issue pipeline controller: init/lock sequencing, stalls, branch flush and halt.
// Build option: define PIPE_CTRL_PERF_EN to include the stall_cnt performance counter.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned RST_CYCLES   = 2,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   locked,
  input  logic                   mem_stall,
  input  logic                   exec_stall,
  input  logic                   haz_stall0,
  input  logic                   haz_stall1,
  input  logic                   wb_branch0,
  input  logic                   wb_branch1,
  input  logic                   wb_halt,
  input  logic                   resume,
  output logic                   fetch_hold,
  output logic                   dec_hold,
  output logic                   issue1_only,
  output logic [1:0]             dex_bubble,
  output logic                   exm_bubble,
  output logic                   stage_freeze,
  output logic                   branch_en,
  output logic                   branch_sel,
  output logic                   halted,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam int unsigned MAX_CYC = (RST_CYCLES > FLUSH_CYCLES) ? RST_CYCLES : FLUSH_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State and shared INIT/FLUSH cycle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and pipeline control decode; RUN controls follow the inputs in the same cycle.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    fetch_hold   = 1'b0;
    dec_hold     = 1'b0;
    issue1_only  = 1'b0;
    dex_bubble   = 2'b00;
    exm_bubble   = 1'b0;
    stage_freeze = 1'b0;
    branch_en    = 1'b0;
    branch_sel   = 1'b0;
    halted       = 1'b0;

    case (state_q)
      ST_INIT: begin
        fetch_hold = 1'b1;
        dex_bubble = 2'b11;
        exm_bubble = 1'b1;
        if (cnt_q >= CNT_W'(RST_CYCLES - 1)) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RUN: begin
        stage_freeze  = mem_stall;
        dec_hold      = mem_stall | exec_stall | haz_stall0;
        issue1_only   = haz_stall1 & ~dec_hold;
        fetch_hold    = dec_hold | haz_stall1;
        dex_bubble[0] = haz_stall0 & ~mem_stall;
        dex_bubble[1] = (haz_stall0 | haz_stall1) & ~mem_stall;
        branch_en     = (wb_branch0 | wb_branch1) & ~mem_stall;
        branch_sel    = ~wb_branch0;
        if (branch_en) begin
          // Taken branch wins over a coincident halt.
          dex_bubble = 2'b11;
          exm_bubble = 1'b1;
          state_d    = (FLUSH_CYCLES == 0) ? ST_RUN : ST_FLUSH;
          cnt_d      = '0;
        end else if (wb_halt && !mem_stall) begin
          state_d = ST_HALT;
        end
      end

      ST_FLUSH: begin
        dex_bubble = 2'b11;
        exm_bubble = 1'b1;
        if (cnt_q >= CNT_W'(FLUSH_CYCLES - 1)) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_HALT: begin
        halted     = 1'b1;
        fetch_hold = 1'b1;
        dex_bubble = 2'b11;
        exm_bubble = 1'b1;
        if (resume) begin
          state_d = ST_RUN;
        end
      end

      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase

    // An unstable clock restarts the init sequence from any state.
    if (!locked) begin
      state_d = ST_INIT;
      cnt_d   = '0;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic perf_en;

  // Only RUN-state decode holds are counted.
  assign perf_en = (state_q == ST_RUN) & dec_hold;

  pipe_ctrl_perf u_perf (
    .clk   (clk),
    .rst   (rst),
    .en    (perf_en),
    .count (stall_cnt)
  );
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized traffic against a cycle model.
module tb_pipe_ctrl;

  localparam int unsigned RST_CYCLES   = 2;
  localparam int unsigned FLUSH_CYCLES = 1;

  logic        clk, rst, locked, mem_stall, exec_stall, haz_stall0, haz_stall1;
  logic        wb_branch0, wb_branch1, wb_halt, resume;
  logic        fetch_hold, dec_hold, issue1_only, exm_bubble, stage_freeze;
  logic        branch_en, branch_sel, halted;
  logic [1:0]  dex_bubble;
  logic [31:0] stall_cnt;

  pipe_ctrl #(.RST_CYCLES(RST_CYCLES), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .clk(clk), .rst(rst), .locked(locked), .mem_stall(mem_stall), .exec_stall(exec_stall),
    .haz_stall0(haz_stall0), .haz_stall1(haz_stall1), .wb_branch0(wb_branch0),
    .wb_branch1(wb_branch1), .wb_halt(wb_halt), .resume(resume),
    .fetch_hold(fetch_hold), .dec_hold(dec_hold), .issue1_only(issue1_only),
    .dex_bubble(dex_bubble), .exm_bubble(exm_bubble), .stage_freeze(stage_freeze),
    .branch_en(branch_en), .branch_sel(branch_sel), .halted(halted), .stall_cnt(stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  // Reference model: remaining init cycles, remaining flush cycles, halt flag, expected counter.
  int          init_left;
  int          flush_left;
  bit          in_halt;
  logic [31:0] perf_exp;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    init_left  = RST_CYCLES;
    flush_left = 0;
    in_halt    = 1'b0;
    perf_exp   = 32'd0;
  endtask

  // One clock: drive inputs, check outputs against the model, advance the model.
  task automatic step(input bit lk, input bit ms, input bit es, input bit h0, input bit h1,
                      input bit b0, input bit b1, input bit hl, input bit rs);
    bit       e_fh, e_dh, e_io, e_exm, e_sf, e_br, e_bs, e_hd, running;
    bit [1:0] e_dex;
    @(negedge clk);
    locked = lk; mem_stall = ms; exec_stall = es; haz_stall0 = h0; haz_stall1 = h1;
    wb_branch0 = b0; wb_branch1 = b1; wb_halt = hl; resume = rs;
    #1;
    {e_fh, e_dh, e_io, e_exm, e_sf, e_br, e_bs, e_hd} = '0;
    e_dex   = 2'b00;
    running = 1'b0;
    if (init_left > 0) begin
      e_fh = 1; e_dex = 2'b11; e_exm = 1;
    end else if (in_halt) begin
      e_hd = 1; e_fh = 1; e_dex = 2'b11; e_exm = 1;
    end else if (flush_left > 0) begin
      e_dex = 2'b11; e_exm = 1;
    end else begin
      running  = 1'b1;
      e_sf     = ms;
      e_dh     = ms | es | h0;
      e_io     = h1 & ~e_dh;
      e_fh     = e_dh | h1;
      e_dex[0] = h0 & ~ms;
      e_dex[1] = (h0 | h1) & ~ms;
      e_br     = (b0 | b1) & ~ms;
      e_bs     = ~b0;
      if (e_br) begin
        e_dex = 2'b11; e_exm = 1;
      end
    end
    chk("fetch_hold",   32'(fetch_hold),   32'(e_fh));
    chk("dec_hold",     32'(dec_hold),     32'(e_dh));
    chk("issue1_only",  32'(issue1_only),  32'(e_io));
    chk("dex_bubble",   32'(dex_bubble),   32'(e_dex));
    chk("exm_bubble",   32'(exm_bubble),   32'(e_exm));
    chk("stage_freeze", 32'(stage_freeze), 32'(e_sf));
    chk("branch_en",    32'(branch_en),    32'(e_br));
    chk("branch_sel",   32'(branch_sel),   32'(e_bs));
    chk("halted",       32'(halted),       32'(e_hd));
    chk("stall_cnt",    stall_cnt,         perf_exp);
`ifdef PIPE_CTRL_PERF_EN
    if (running && e_dh && perf_exp != 32'hFFFF_FFFF) perf_exp = perf_exp + 32'd1;
`endif
    if (!lk) begin
      init_left = RST_CYCLES; flush_left = 0; in_halt = 1'b0;
    end else if (init_left > 0) begin
      init_left--;
    end else if (in_halt) begin
      if (rs) in_halt = 1'b0;
    end else if (flush_left > 0) begin
      flush_left--;
    end else if (e_br) begin
      flush_left = FLUSH_CYCLES;
    end else if (hl && !ms) begin
      in_halt = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; locked = 1'b1; mem_stall = 0; exec_stall = 0; haz_stall0 = 0; haz_stall1 = 0;
    wb_branch0 = 0; wb_branch1 = 0; wb_halt = 0; resume = 0;
    model_reset();

    // Reset values while rst is held.
    @(negedge clk); #1;
    chk("rst_fetch_hold", 32'(fetch_hold), 32'd1);
    chk("rst_dex_bubble", 32'(dex_bubble), 32'd3);
    chk("rst_exm_bubble", 32'(exm_bubble), 32'd1);
    chk("rst_halted",     32'(halted),     32'd0);
    chk("rst_branch_en",  32'(branch_en),  32'd0);
    chk("rst_stall_cnt",  stall_cnt,       32'd0);

    // Release between edges so the first checked cycle is INIT count 0.
    @(posedge clk); #2 rst = 1'b0;
    idle(4);

    // Dual branch: pipe 0 target wins, then one flush cycle.
    step(1, 0, 0, 0, 0, 1, 1, 0, 0);
    idle(3);

    // Pipe-1 branch deferred under mem_stall, taken when it falls.
    repeat (3) step(1, 1, 0, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(2);

    // Hazards.
    step(1, 0, 0, 0, 1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 1, 0, 0, 0, 0);
    idle(1);

    // Halt, branch ignored while halted, resume.
    step(1, 0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 1, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(2);

    // Branch and halt together: branch has priority.
    step(1, 0, 0, 0, 0, 1, 0, 1, 0);
    idle(3);

    // Lock loss in RUN restarts INIT.
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(4);

    // Five RUN cycles of exec_stall.
    repeat (5) step(1, 0, 1, 0, 0, 0, 0, 0, 0);
    idle(2);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 60) != 0, $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 12) == 0, $urandom_range(0, 3) == 0);
    end

    // Asynchronous reset mid-run takes effect without a clock edge.
    @(negedge clk); rst = 1'b1; #1;
    chk("arst_fetch_hold", 32'(fetch_hold), 32'd1);
    chk("arst_dex_bubble", 32'(dex_bubble), 32'd3);
    chk("arst_halted",     32'(halted),     32'd0);
    chk("arst_stall_cnt",  stall_cnt,       32'd0);
    model_reset();
    @(posedge clk); #2 rst = 1'b0;
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
